// File: rtl/tiny_cpu_pkg.sv
// Shared opcode constants, NOP word and sequencer FSM states for the TinyCpu slice.
package tiny_cpu_pkg;

  localparam logic [3:0] CLR  = 4'd0;
  localparam logic [3:0] WRA  = 4'd1;
  localparam logic [3:0] WRB  = 4'd2;
  localparam logic [3:0] MOVB = 4'd3;
  localparam logic [3:0] ADD  = 4'd4;
  localparam logic [3:0] SHR  = 4'd6;
  localparam logic [3:0] XOR  = 4'd9;
  localparam logic [3:0] CMP  = 4'd11;
  localparam logic [3:0] NOP  = 4'd15;

  localparam logic [11:0] NOP_WORD = 12'hF00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    FINISH = 2'd2
  } seq_state_t;

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for the sequencer: one synchronous write port, one asynchronous read port.
module seq_prog_mem #(
  parameter int DEPTH = 16,
  parameter int IW    = 12,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tiny_cpu_sequencer.sv
// Presents a stored program to TinyCpu, each word held for HOLD cycles.
// Define SEQ_LOOP_EN to add the Loop input that makes runs repeat instead of finishing.
module tiny_cpu_sequencer
  import tiny_cpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IW    = 12,
  parameter int HOLD  = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          LoadEn,
  input  logic [AW-1:0] LoadAddr,
  input  logic [IW-1:0] LoadData,
  input  logic          Start,
  input  logic [LW-1:0] Length,
`ifdef SEQ_LOOP_EN
  input  logic          Loop,
`endif
  output logic [IW-1:0] Instr,
  output logic          InstrValid,
  output logic [AW-1:0] Pc,
  output logic          Busy,
  output logic          Done
);

  localparam logic [7:0]    HOLD_LAST = 8'(HOLD - 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [IW-1:0] NOP_I     = IW'(NOP_WORD);

  seq_state_t    state, state_n;
  logic [7:0]    cnt, cnt_n;
  logic [LW-1:0] len, len_n;
  logic [AW-1:0] pc_n;
  logic [IW-1:0] instr_n;
  logic          vld_n, done_n;
  logic          mem_we, loop_en, last_hold, last_slot;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_data, fetch;

`ifdef SEQ_LOOP_EN
  assign loop_en = Loop;
`else
  assign loop_en = 1'b0;
`endif

  assign mem_we    = LoadEn && (state == IDLE);
  assign last_hold = (cnt == HOLD_LAST);
  assign last_slot = ({1'b0, Pc} == (len - LW'(1)));
  // Next word to present: slot 0 on start or wrap, otherwise the following slot.
  assign rd_addr   = (state == ISSUE && !last_slot) ? Pc + AW'(1) : '0;
  // A write in the same cycle as Start must be visible to the first fetch.
  assign fetch     = (mem_we && LoadAddr == rd_addr) ? LoadData : rd_data;

  seq_prog_mem #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) u_mem (
    .clk   (Clk),
    .we    (mem_we),
    .waddr (LoadAddr),
    .wdata (LoadData),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len;
    pc_n    = Pc;
    instr_n = Instr;
    vld_n   = InstrValid;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          len_n = (Length > DEPTH_L) ? DEPTH_L : Length;
          pc_n  = '0;
          cnt_n = '0;
          if (Length == '0) begin
            state_n = FINISH;
            done_n  = 1'b1;
          end else begin
            state_n = ISSUE;
            instr_n = fetch;
            vld_n   = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (!last_hold) begin
          cnt_n = cnt + 8'd1;
        end else begin
          cnt_n = '0;
          if (!last_slot) begin
            pc_n    = Pc + AW'(1);
            instr_n = fetch;
          end else if (loop_en) begin
            pc_n    = '0;
            instr_n = fetch;
          end else begin
            state_n = FINISH;
            instr_n = NOP_I;
            vld_n   = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt        <= '0;
      len        <= '0;
      Pc         <= '0;
      Instr      <= NOP_I;
      InstrValid <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      len        <= len_n;
      Pc         <= pc_n;
      Instr      <= instr_n;
      InstrValid <= vld_n;
      Busy       <= (state_n != IDLE);
      Done       <= done_n;
    end
  end

endmodule

// File: tb/tb_tiny_cpu_sequencer.sv
// Scoreboard bench for tiny_cpu_sequencer: expected issue trace queued at Start, checked by a monitor.
module tb_tiny_cpu_sequencer;

  localparam int DEPTH = 16;
  localparam int IW    = 12;
  localparam int HOLD  = 4;
  localparam int AW    = 4;
  localparam int LW    = 5;
  localparam logic [IW-1:0] NOPW = 12'hF00;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          LoadEn = 1'b0;
  logic [AW-1:0] LoadAddr = '0;
  logic [IW-1:0] LoadData = '0;
  logic          Start = 1'b0;
  logic [LW-1:0] Length = '0;
`ifdef SEQ_LOOP_EN
  logic          Loop = 1'b0;
`endif
  logic [IW-1:0] Instr;
  logic          InstrValid;
  logic [AW-1:0] Pc;
  logic          Busy;
  logic          Done;

  tiny_cpu_sequencer #(.DEPTH(DEPTH), .IW(IW), .HOLD(HOLD)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .LoadEn     (LoadEn),
    .LoadAddr   (LoadAddr),
    .LoadData   (LoadData),
    .Start      (Start),
    .Length     (Length),
`ifdef SEQ_LOOP_EN
    .Loop       (Loop),
`endif
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .Pc         (Pc),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  typedef struct {
    int            stamp;
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    logic          done;
  } exp_t;

  exp_t          q[$];
  exp_t          e;
  logic [IW-1:0] model [DEPTH];
  int            vectors = 0;
  int            miscompares = 0;

  // Monitor: every valid word or Done pulse must match the next queued expectation.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (InstrValid || Done) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_output cyc=%0d valid=%0b done=%0b instr=%h pc=%0d, nothing expected",
                   cyc, InstrValid, Done, Instr, Pc);
        end else begin
          e = q.pop_front();
          if (e.stamp != cyc || Done !== e.done || InstrValid !== !e.done ||
              (!e.done && (Instr !== e.instr || Pc !== e.pc))) begin
            miscompares++;
            $display("FAIL seq_item got cyc=%0d valid=%0b done=%0b instr=%h pc=%0d, expected cyc=%0d done=%0b instr=%h pc=%0d",
                     cyc, InstrValid, Done, Instr, Pc, e.stamp, e.done, e.instr, e.pc);
          end
        end
      end
      if (!InstrValid) begin
        vectors++;
        if (Instr !== NOPW) begin
          miscompares++;
          $display("FAIL idle_nop cyc=%0d instr=%h expected=%h", cyc, Instr, NOPW);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic load(input int a, input logic [IW-1:0] d);
    LoadEn = 1'b1; LoadAddr = AW'(a); LoadData = d;
    if (!Busy) model[a] = d;
    tick();
    LoadEn = 1'b0;
  endtask

  task automatic start_run(input int len, input int passes, input bit ld,
                           input int la, input logic [IW-1:0] ldd);
    int   eff;
    int   t;
    exp_t it;
    eff = (len > DEPTH) ? DEPTH : len;
    t   = cyc + 1;
    if (ld) model[la] = ldd;
    for (int p = 0; p < passes; p++)
      for (int s = 0; s < eff; s++)
        for (int h = 0; h < HOLD; h++) begin
          it.stamp = t; it.instr = model[s]; it.pc = AW'(s); it.done = 1'b0;
          q.push_back(it);
          t++;
        end
    it.stamp = t; it.instr = '0; it.pc = '0; it.done = 1'b1;
    q.push_back(it);
    Start = 1'b1; Length = LW'(len);
    LoadEn = ld; LoadAddr = AW'(la); LoadData = ldd;
    tick();
    Start = 1'b0; LoadEn = 1'b0;
  endtask

  task automatic finish_run(input bit junk);
    int n;
    n = 0;
    while (Busy && n < 300) begin
      if (junk) begin
        LoadEn   = 1'($urandom_range(0, 1));
        LoadAddr = AW'($urandom);
        LoadData = IW'($urandom);
        Start    = 1'($urandom_range(0, 1));
        Length   = LW'($urandom);
      end
      tick();
      n++;
    end
    LoadEn = 1'b0; Start = 1'b0;
    chk("run_timeout_busy", 32'(Busy), 32'd0);
    tick();
    chk("pending_expectations", q.size(), 32'd0);
    q = {};
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_instr", 32'(Instr), 32'(NOPW));
    chk("rst_valid", 32'(InstrValid), 32'd0);
    chk("rst_pc", 32'(Pc), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    Reset = 1'b0;
    tick();

    // Reference program, eight words, held four cycles each
    load(0, 12'h000); load(1, 12'h107); load(2, 12'h208); load(3, 12'h400);
    load(4, 12'h900); load(5, 12'hB00); load(6, 12'h600); load(7, 12'h300);
    start_run(8, 1, 1'b0, 0, '0);
    chk("busy_in_run", 32'(Busy), 32'd1);
    finish_run(1'b0);

    // Zero-length run: Done next cycle, nothing issued
    start_run(0, 1, 1'b0, 0, '0);
    finish_run(1'b0);

    // Write while busy must be dropped
    start_run(3, 1, 1'b0, 0, '0);
    load(2, 12'h4FF);
    finish_run(1'b0);
    start_run(3, 1, 1'b0, 0, '0);
    finish_run(1'b0);

    // Over-long length saturates to DEPTH
    for (int i = 8; i < DEPTH; i++) load(i, IW'($urandom));
    start_run(20, 1, 1'b0, 0, '0);
    finish_run(1'b0);

    // Reset during slot 3 aborts without Done, next run starts from slot 0
    start_run(8, 1, 1'b0, 0, '0);
    for (int n = 0; n < 100 && !(InstrValid && Pc == AW'(3)); n++) tick();
    chk("reached_slot3", 32'(Pc), 32'd3);
    Reset = 1'b1;
    #1;
    q = {};
    chk("abort_instr", 32'(Instr), 32'(NOPW));
    chk("abort_valid", 32'(InstrValid), 32'd0);
    chk("abort_pc", 32'(Pc), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    tick();
    Reset = 1'b0;
    tick();
    chk("post_abort_busy", 32'(Busy), 32'd0);
    start_run(5, 1, 1'b0, 0, '0);
    finish_run(1'b0);

    // Load and Start together: first word is the freshly written one
    start_run(4, 1, 1'b1, 0, 12'h123);
    finish_run(1'b0);

`ifdef SEQ_LOOP_EN
    Loop = 1'b1;
    start_run(2, 3, 1'b0, 0, '0);
    repeat (2 * 2 * HOLD) @(posedge Clk);
    #1;
    Loop = 1'b0;
    finish_run(1'b0);
`endif

    // Randomized runs with background loads and ignored traffic while busy
    for (int r = 0; r < 14; r++) begin
      int nl;
      nl = $urandom_range(0, 3);
      for (int k = 0; k < nl; k++) load($urandom_range(0, DEPTH - 1), IW'($urandom));
      start_run($urandom_range(0, 20), 1, 1'($urandom_range(0, 1)),
                $urandom_range(0, DEPTH - 1), IW'($urandom));
      finish_run(1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tiny_cpu_sequencer.md
TINY_CPU_SEQUENCER -- requirements
Module: tiny_cpu_sequencer

Interface
REQ-001 The block SHALL have one clock, Clk; reset SHALL be Reset, asynchronous and active-high.
REQ-002 Parameter DEPTH, default 16, SHALL set the number of program slots.
REQ-003 Parameter IW, default 12, SHALL set the instruction width.
REQ-004 Parameter HOLD, default 4, SHALL set the cycles each instruction is presented; legal range is 1..255.
REQ-005 Ports SHALL be:
  Clk  in  1  clock, rising edge
  Reset  in  1  async active-high reset
  LoadEn  in  1  write LoadData to slot LoadAddr
  LoadAddr  in  log2(DEPTH)  program slot address
  LoadData  in  IW  instruction word to store
  Start  in  1  begin a run, sampled in IDLE only
  Length  in  log2(DEPTH)+1  instruction count, sampled with Start
  Instr  out  IW  instruction driven to the TinyCpu In port
  InstrValid  out  1  Instr carries a program word
  Pc  out  log2(DEPTH)  current slot index
  Busy  out  1  run in progress
  Done  out  1  one-cycle pulse at run end

Function
REQ-006 The FSM SHALL have three states: IDLE, ISSUE and FINISH.
REQ-007 IDLE: Start=1 with Length!=0 SHALL go to ISSUE with Pc=0 and the hold counter at 0.
REQ-008 IDLE: Start=1 with Length=0 SHALL go to FINISH and SHALL issue nothing.
REQ-009 Length>DEPTH SHALL saturate to DEPTH.
REQ-010 ISSUE: Instr SHALL equal mem[Pc] and InstrValid=1, starting the cycle after Start is sampled.
REQ-011 ISSUE: the hold counter SHALL increment each cycle.
REQ-012 At count HOLD-1 the counter SHALL clear and Pc SHALL increment, unless Pc=Length-1, in which case the state SHALL go to FINISH.
REQ-013 FINISH SHALL assert Done for exactly one cycle and then return to IDLE.
REQ-014 In IDLE and FINISH, Instr SHALL be NOP (12'hF00) and InstrValid SHALL be 0.
REQ-015 Busy SHALL be 1 in ISSUE and FINISH and 0 in IDLE.
REQ-016 Register writes from LoadEn SHALL take effect in IDLE only; LoadEn while Busy SHALL be ignored.
REQ-017 Start while Busy SHALL be ignored.
REQ-018 When LoadEn and Start are both 1 in IDLE, the write SHALL complete and the run SHALL start; slot contents read during the run are the post-write contents.
REQ-019 Instr, InstrValid, Pc, Busy and Done SHALL all be registered outputs.

Reset
REQ-020 Reset SHALL force state IDLE, Pc=0, hold counter=0, Instr=NOP, InstrValid=0, Busy=0 and Done=0.
REQ-021 Reset mid-run SHALL abort the run with no Done pulse.
REQ-022 Program memory SHALL NOT be cleared by Reset.

Configuration
REQ-023 With SEQ_LOOP_EN defined, the block SHALL have an input port Loop (1 bit).
REQ-024 With SEQ_LOOP_EN defined and Loop=1 at the final slot's last hold cycle, Pc SHALL wrap to 0, the block SHALL stay in ISSUE and Done SHALL NOT pulse.
REQ-025 Without SEQ_LOOP_EN, the Loop port SHALL be absent and every run SHALL be one-shot.

Structure
REQ-026 Package tiny_cpu_pkg SHALL hold the opcode constants (CLR=0, WRA=1, WRB=2, MOVB=3, ADD=4, SHR=6, XOR=9, CMP=11, NOP=15), the NOP word, and the FSM state enum.
REQ-027 Program storage SHALL be a sub-module, seq_prog_mem: DEPTH x IW, one synchronous write port and one asynchronous read port.

Verification
REQ-028 Load 000,107,208,400,900,B00,600,300 with Length=8, HOLD=4 -> each word is valid for 4 cycles in order, Done pulses once 33 cycles after Start, and the attached TinyCpu Result ends at 8'h03.
REQ-029 Start with Length=0 -> Done pulses the next cycle and InstrValid stays 0.
REQ-030 Reset asserted during slot 3 -> outputs return to reset values immediately, there is no Done, and a new Start reruns from slot 0.
REQ-031 LoadEn to slot 2 with data 12'h4FF while Busy -> slot 2 still reads its old value in the next run.
REQ-032 Length=20 -> exactly 16 instructions are issued.
REQ-033 With SEQ_LOOP_EN, Loop=1 and Length=2 -> the sequence repeats slot 0, slot 1, slot 0, ...; dropping Loop -> Done pulses after the next slot-1 hold.
